// File: rtl/ex_mem_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_pkg
// Shared constants for the EX->MEM pipeline stage: bus width defaults, the
// NOP/idle encodings a killed or reset stage presents to MEM, and the
// active-low reset level.
// No ports (package).
// ---------------------------------------------------------------------------
package ex_mem_pipe_pkg;

  // Width defaults (AluOpBus / RegBus / RegAddrBus)
  localparam int AluOpBusW   = 8;
  localparam int RegBusW     = 32;
  localparam int RegAddrBusW = 5;

  // Idle encodings
  localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'b0_0000;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        WriteEnable  = 1'b1;

  // rst is active low: this is the level that resets.
  localparam logic        RstEnable_n  = 1'b0;

  // Width of the packed {waddr, we, wdata, aluop, mem_addr, rt_data} bundle.
  function automatic int pay_width(input int data_w, input int raddr_w,
                                   input int aluop_w);
    return raddr_w + 1 + 3 * data_w + aluop_w;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_if.sv
// ---------------------------------------------------------------------------
// ex_mem_if
// One EX->MEM result bundle plus its handshake. One instance carries the
// upstream (EX side) link, another the downstream (MEM side) link.
//
// Handshake: the master drives valid and the payload; the slave drives ready.
// A bundle moves on a posedge where valid & ready are both 1. While valid=1
// and ready=0 the master keeps valid and payload bit-stable.
//
// Modports:
//   master : drives valid/payload, samples ready
//   slave  : samples valid/payload, drives ready
// ---------------------------------------------------------------------------
interface ex_mem_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int ALUOP_W = 8
) ();

  logic               valid;
  logic               ready;
  logic [RADDR_W-1:0] reg_waddr;
  logic               reg_we;
  logic [DATA_W-1:0]  reg_wdata;
  logic [ALUOP_W-1:0] aluop;
  logic [DATA_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  rt_data;

  modport master (
    output valid, reg_waddr, reg_we, reg_wdata, aluop, mem_addr, rt_data,
    input  ready
  );

  modport slave (
    input  valid, reg_waddr, reg_we, reg_wdata, aluop, mem_addr, rt_data,
    output ready
  );

endinterface

// File: rtl/ex_mem_pipe_skid.sv
// ---------------------------------------------------------------------------
// ex_mem_skid
// Single holding register with valid bit. Catches a bundle accepted while the
// main stage register is full and stalled, and hands it back when the main
// register drains.
// Ports:
//   clk, rst  : clock, synchronous active-low reset
//   flush     : clear the held entry
//   load_i    : capture data_i (main full and stalled this cycle)
//   drain_i   : entry moves into the main register this cycle
//   data_i    : incoming packed bundle
//   valid_o   : entry held
//   data_o    : held packed bundle
// ---------------------------------------------------------------------------
module ex_mem_skid
  import ex_mem_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // load and drain never coincide: the upstream is not ready while full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe
// EX->MEM pipeline register with valid/ready handshake, stall and flush.
// Hazard/exception logic can hold the stage (mem_o.ready=0) or kill it
// (flush=1). Reset takes priority over flush.
//
// Ports:
//   clk    : clock, all state on posedge
//   rst    : synchronous reset, active low
//   flush  : drop the held entry (or entries) and any incoming bundle
//   ex_i   : ex_mem_if.slave  - bundle from EX, ex_i.ready driven here
//   mem_o  : ex_mem_if.master - bundle to MEM, mem_o.ready from MEM
//
// Build option EX_MEM_SKID_EN: adds a skid entry so ex_i.ready is a flop
// output with no combinational path from mem_o.ready. Without it the stage
// is a single register and ex_i.ready = ~mem_valid | mem_ready.
// ---------------------------------------------------------------------------
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W  = RegBusW,
  parameter int RADDR_W = RegAddrBusW,
  parameter int ALUOP_W = AluOpBusW
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  ex_mem_if.slave  ex_i,
  ex_mem_if.master mem_o
);

  localparam int PAY_W = pay_width(DATA_W, RADDR_W, ALUOP_W);

  // Field positions inside the packed bundle (rt_data in the low bits).
  localparam int RT_LSB    = 0;
  localparam int ADDR_LSB  = DATA_W;
  localparam int ALUOP_LSB = 2 * DATA_W;
  localparam int WDATA_LSB = 2 * DATA_W + ALUOP_W;
  localparam int WE_BIT    = 3 * DATA_W + ALUOP_W;
  localparam int WADDR_LSB = WE_BIT + 1;

  localparam logic [PAY_W-1:0] RST_PAY = {
    RADDR_W'(NOPRegAddr), WriteDisable, DATA_W'(ZeroWord),
    ALUOP_W'(EXE_NOP_OP), DATA_W'(ZeroWord), DATA_W'(ZeroWord)
  };

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] main_pay_q, main_pay_d;
  logic             main_valid_q, main_valid_d;
  logic             ex_ready;
  logic             accept;
  logic             xfer_out;

  assign in_pay = {ex_i.reg_waddr, ex_i.reg_we, ex_i.reg_wdata,
                   ex_i.aluop, ex_i.mem_addr, ex_i.rt_data};

  assign accept   = ex_i.valid & ex_ready;
  assign xfer_out = main_valid_q & mem_o.ready;

`ifdef EX_MEM_SKID_EN
  logic             skid_valid;
  logic             skid_load;
  logic             skid_drain;
  logic [PAY_W-1:0] skid_pay;

  // Upstream sees space as long as the skid slot is free; this only
  // depends on a flop, not on mem_o.ready.
  assign ex_ready   = ~skid_valid;
  assign skid_load  = accept & main_valid_q & ~mem_o.ready;
  assign skid_drain = xfer_out & skid_valid;

  ex_mem_skid #(.W(PAY_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .data_i  (in_pay),
    .valid_o (skid_valid),
    .data_o  (skid_pay)
  );

  always_comb begin
    main_valid_d = main_valid_q;
    main_pay_d   = main_pay_q;
    if (flush) begin
      main_valid_d                         = 1'b0;
      main_pay_d[WE_BIT]                   = WriteDisable;
      main_pay_d[ALUOP_LSB +: ALUOP_W]     = ALUOP_W'(EXE_NOP_OP);
    end else if (skid_drain) begin
      // Older bundle waiting in skid goes first to preserve order.
      main_valid_d = 1'b1;
      main_pay_d   = skid_pay;
    end else if (accept & (~main_valid_q | xfer_out)) begin
      main_valid_d = 1'b1;
      main_pay_d   = in_pay;
    end else if (xfer_out) begin
      main_valid_d = 1'b0;
    end
  end
`else
  // Single register: can take a new bundle when empty or when the current
  // one leaves this same cycle.
  assign ex_ready = ~main_valid_q | mem_o.ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_pay_d   = main_pay_q;
    if (flush) begin
      main_valid_d                         = 1'b0;
      main_pay_d[WE_BIT]                   = WriteDisable;
      main_pay_d[ALUOP_LSB +: ALUOP_W]     = ALUOP_W'(EXE_NOP_OP);
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_pay_d   = in_pay;
    end else if (xfer_out) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst == RstEnable_n) begin
      main_valid_q <= 1'b0;
      main_pay_q   <= RST_PAY;
    end else begin
      main_valid_q <= main_valid_d;
      main_pay_q   <= main_pay_d;
    end
  end

  assign ex_i.ready = ex_ready;

  assign mem_o.valid     = main_valid_q;
  assign mem_o.reg_waddr = main_pay_q[WADDR_LSB +: RADDR_W];
  // A bubble never writes the register file.
  assign mem_o.reg_we    = main_pay_q[WE_BIT] & main_valid_q;
  assign mem_o.reg_wdata = main_pay_q[WDATA_LSB +: DATA_W];
  assign mem_o.aluop     = main_pay_q[ALUOP_LSB +: ALUOP_W];
  assign mem_o.mem_addr  = main_pay_q[ADDR_LSB +: DATA_W];
  assign mem_o.rt_data   = main_pay_q[RT_LSB +: DATA_W];

endmodule
